rf16_access_ctrl: RTL and testbench
===================================

# rf16_access_ctrl

Sequencer and arbiter for the shared 16-entry register-file port. Two requesters (A, B) compete for single read/write access to the array, and the block owns the array's `ren`/`wen`/address/data controls. It also holds a sticky write lock: once set, the lock blocks writes to the protected upper address range until reset. No requester-side signal can override the lock.

## Interface
Parameters:
- `DW`, 8: data width of one register-file entry.
- `AW`, 4: address width (16 entries).
- `PROT_BASE`, 8: addresses ≥ `PROT_BASE` are write-protected while locked.

Ports (clock and reset first):
- `rd_clk`, in, 1: single clock; all state updates on rising edge.
- `reset_l`, in, 1: reset, asynchronous and active-low.
- `a_req` / `b_req`, in, 1: access request; held high until the matching grant.
- `a_we` / `b_we`, in, 1: 1 = write, 0 = read; valid with req.
- `a_addr` / `b_addr`, in, `AW`: entry address.
- `a_wdata` / `b_wdata`, in, `DW`: write data.
- `a_gnt` / `b_gnt`, out, 1: one-cycle grant pulse; command captured this cycle.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_id`, out, 1: owner of the response (0 = A, 1 = B).
- `rsp_err`, out, 1: write rejected by the lock.
- `rsp_rdata`, out, `DW`: read data (0 for writes).
- `lk_set`, in, 1: pulse that sets the lock; only reset clears it.
- `lk_status`, out, 1: current lock state.
- `rf_ren` / `rf_wen`, out, 1: array read/write enable.
- `rf_addr`, out, `AW`: array address.
- `rf_wdata`, out, `DW`: array write data.
- `rf_rdata`, in, `DW`: array read data, valid the cycle after `rf_ren`.

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE.
- **IDLE**
  - If any req, arbitrate and pulse the winner's gnt.
  - Latch `we`, `addr`, `wdata`, `id` into the command register, then go to ACCESS.
  - With no req, stay in IDLE.
- **Arbitration** is round-robin.
  - Single requester always wins.
  - When both request, the winner is the requester not granted last.
  - `last_id` resets to B, so A wins the first tie.
- **ACCESS**
  - Read: `rf_ren`=1.
  - Write with `lock_q`=0, or `addr` < `PROT_BASE`: `rf_wen`=1 and `rf_wdata`=cmd data.
  - Write with `lock_q`=1 and `addr` ≥ `PROT_BASE`: `rf_wen` stays 0 and the error flag is latched. There is no bypass term.
  - `rf_addr` = cmd addr. Then go to RESP.
- **RESP**
  - `rsp_valid`=1 and `rsp_id` = cmd id.
  - `rsp_rdata` = `rf_rdata` for reads, 0 for writes.
  - `rsp_err` = latched flag.
  - Return to IDLE.
- **Lock**
  - `lock_q` is set by `lk_set`; it is never cleared except by reset.
  - `lk_status` = `lock_q`.
- Reads are never blocked. `rsp_err` is 0 for every read.

## Timing
- Latency: gnt in cycle N, array enable in N+1, `rsp_valid` in N+2.
- Next grant earliest N+3; throughput is one access per 3 cycles.
- `lk_set` sampled in cycle N takes effect from N+1. A lock set in the grant cycle therefore blocks that write's ACCESS.
- Requests arriving in ACCESS/RESP wait. Their req must stay high; no grant is issued outside IDLE.
- Reset values (asynchronous, at `reset_l` falling edge):
  - state = IDLE, `lock_q` = 0, `last_id` = B.
  - All outputs 0: gnt, `rsp_*`, `rf_*` enables, addr, wdata.
- Reset during ACCESS: the in-flight write is aborted and `rf_wen` drops immediately; no response is issued.
- All `rf_*` and `rsp_*` outputs are registered or decoded from state. They are 0 in states where they are inactive.

## Structure
- Package `rf_ctrl_pkg` holds:
  - state enum `rf_state_e` {IDLE, ACCESS, RESP};
  - `req_id_t` (1-bit, `ID_A` = 0, `ID_B` = 1);
  - command struct `rf_cmd_t` {we, addr, wdata, id}.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with a `last_id` register and an `advance` input, driven by the FSM in IDLE.
- Top-level: FSM, command register, lock register, error flag, array-control decode.

## Test plan
- Reset: assert `reset_l`=0 mid-ACCESS with a write in flight → `rf_wen` drops to 0 at once, all outputs 0, `lk_status`=0, no `rsp_valid` after release.
- Read: A reads addr 3 with `rf_rdata`=0xA5 → `a_gnt` at N, `rf_ren` with addr 3 at N+1, `rsp_valid`/`rsp_id`=0/`rsp_rdata`=0xA5 at N+2.
- Arbitration: A and B request continuously from reset → grants A, B, A, B at 3-cycle spacing.
- Locked write: `lk_set`, then B writes 0x5A to addr 9 → `rf_wen` stays 0, `rsp_err`=1. The same write to addr 3 gives `rf_wen`=1 and `rsp_err`=0.
- Lock race: `lk_set` pulsed in the same cycle as `a_gnt` for a write to addr 12 → write blocked, `rsp_err`=1.
- Lock stickiness: `lk_set` pulsed, then 50 idle cycles with toggling requests → `lk_status` stays 1 until `reset_l`=0.

Source files
------------

// File: rtl/rf16_access_ctrl_pkg.sv
// Shared types for the 16-entry register-file access controller.
// Command fields are sized by RF_DW/RF_AW, so the top-level DW/AW must match them.
package rf_ctrl_pkg;

    localparam int RF_DW = 8;
    localparam int RF_AW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } rf_state_e;

    typedef logic req_id_t;
    localparam req_id_t ID_A = 1'b0;
    localparam req_id_t ID_B = 1'b1;

    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] wdata;
        req_id_t          id;
    } rf_cmd_t;

    // True when a write would land in the lockable upper range.
    function automatic logic in_prot_range(input logic [RF_AW-1:0] addr,
                                           input logic [RF_AW-1:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/rf16_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
// last_id only moves when the owner commits a grant via i_advance.
module rr_arb2
    import rf_ctrl_pkg::*;
(
    input  logic    rd_clk,
    input  logic    reset_l,
    input  logic    i_req_a,
    input  logic    i_req_b,
    input  logic    i_advance,
    output logic    o_vld,
    output req_id_t o_id
);

    req_id_t r_last_id;
    req_id_t w_id;

    always_comb begin
        w_id = ID_A;
        if (i_req_a && i_req_b) begin
            w_id = (r_last_id == ID_B) ? ID_A : ID_B;
        end else if (i_req_b) begin
            w_id = ID_B;
        end
    end

    // Reset to B so that A takes the first tie.
    always_ff @(posedge rd_clk or negedge reset_l) begin
        if (!reset_l) begin
            r_last_id <= ID_B;
        end else if (i_advance && (i_req_a || i_req_b)) begin
            r_last_id <= w_id;
        end
    end

    assign o_vld = i_req_a | i_req_b;
    assign o_id  = w_id;

endmodule

// File: rtl/rf16_access_ctrl.sv
// Sequencer/arbiter for the shared register-file port with a sticky write lock.
// One access per three cycles: grant (IDLE), array strobe (ACCESS), response (RESP).
module rf16_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int DW        = RF_DW,
    parameter int AW        = RF_AW,
    parameter int PROT_BASE = 8
) (
    input  logic          rd_clk,
    input  logic          reset_l,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    input  logic          lk_set,
    output logic          lk_status,
    output logic          rf_ren,
    output logic          rf_wen,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    localparam logic [AW-1:0] PB = AW'(PROT_BASE);

    rf_state_e r_state;
    rf_state_e w_state_nxt;
    rf_cmd_t   r_cmd;
    logic      r_lock;
    logic      r_err;

    logic      w_arb_vld;
    req_id_t   w_arb_id;
    logic      w_take;
    logic      w_block;
    rf_cmd_t   w_cmd_in;

    rr_arb2 u_arb (
        .rd_clk    (rd_clk),
        .reset_l   (reset_l),
        .i_req_a   (a_req),
        .i_req_b   (b_req),
        .i_advance (r_state == IDLE),
        .o_vld     (w_arb_vld),
        .o_id      (w_arb_id)
    );

    assign w_take = (r_state == IDLE) && w_arb_vld;

    always_comb begin
        w_cmd_in.id = w_arb_id;
        if (w_arb_id == ID_A) begin
            w_cmd_in.we    = a_we;
            w_cmd_in.addr  = a_addr;
            w_cmd_in.wdata = a_wdata;
        end else begin
            w_cmd_in.we    = b_we;
            w_cmd_in.addr  = b_addr;
            w_cmd_in.wdata = b_wdata;
        end
    end

    // Lock is checked live in ACCESS, so a lock set in the grant cycle still blocks.
    assign w_block = r_cmd.we && r_lock && in_prot_range(r_cmd.addr, PB);

    always_ff @(posedge rd_clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb_vld) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge reset_l) begin
        if (!reset_l) begin
            r_cmd  <= '0;
            r_err  <= 1'b0;
            r_lock <= 1'b0;
        end else begin
            r_lock <= r_lock | lk_set;
            if (w_take) begin
                r_cmd <= w_cmd_in;
            end
            if (r_state == ACCESS) begin
                r_err <= w_block;
            end
        end
    end

    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        rf_ren    = 1'b0;
        rf_wen    = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        rsp_valid = 1'b0;
        rsp_id    = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (r_state)
            IDLE: begin
                // Gated by reset so no grant escapes while reset is held.
                a_gnt = reset_l && w_arb_vld && (w_arb_id == ID_A);
                b_gnt = reset_l && w_arb_vld && (w_arb_id == ID_B);
            end
            ACCESS: begin
                rf_addr = r_cmd.addr;
                if (!r_cmd.we) begin
                    rf_ren = 1'b1;
                end else if (!w_block) begin
                    rf_wen   = 1'b1;
                    rf_wdata = r_cmd.wdata;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = r_cmd.id;
                rsp_err   = r_err;
                if (!r_cmd.we) begin
                    rsp_rdata = rf_rdata;
                end
            end
            default: ;
        endcase
    end

    assign lk_status = r_lock;

endmodule

// File: tb/tb_rf16_access_ctrl.sv
// Directed bench for rf16_access_ctrl: table of single transactions plus
// hand-written reset, arbitration, lock-race and stickiness sequences.
module tb_rf16_access_ctrl;

    logic       rd_clk = 1'b0;
    logic       reset_l;
    logic       a_req, a_we, b_req, b_we, lk_set;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata, rf_rdata;
    logic       a_gnt, b_gnt, rsp_valid, rsp_id, rsp_err, lk_status, rf_ren, rf_wen;
    logic [7:0] rsp_rdata, rf_wdata;
    logic [3:0] rf_addr;

    int n_tests = 0;
    int n_fail  = 0;
    logic lk_exp = 1'b0;

    always #5 rd_clk = ~rd_clk;

    rf16_access_ctrl #(.DW(8), .AW(4), .PROT_BASE(8)) dut (
        .rd_clk(rd_clk), .reset_l(reset_l),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .lk_set(lk_set), .lk_status(lk_status),
        .rf_ren(rf_ren), .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    typedef struct {
        logic       a_req, b_req, a_we, b_we;
        logic [3:0] a_addr, b_addr;
        logic [7:0] a_wd, b_wd;
        logic       lk;
        logic [7:0] rdata;
        logic       exp_id, exp_ren, exp_wen;
        logic [3:0] exp_addr;
        logic [7:0] exp_wdata;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic ar, logic br, logic aw, logic bw,
                                logic [3:0] aa, logic [3:0] ba, logic [7:0] ad, logic [7:0] bd,
                                logic lk, logic [7:0] rd, logic id, logic ren, logic wen,
                                logic [3:0] ea, logic [7:0] ew, logic err, logic [7:0] er);
        vec_t v;
        v.a_req = ar; v.b_req = br; v.a_we = aw; v.b_we = bw;
        v.a_addr = aa; v.b_addr = ba; v.a_wd = ad; v.b_wd = bd;
        v.lk = lk; v.rdata = rd; v.exp_id = id; v.exp_ren = ren; v.exp_wen = wen;
        v.exp_addr = ea; v.exp_wdata = ew; v.exp_err = err; v.exp_rdata = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".a_gnt"},     32'(a_gnt),     0);
        chk({nm, ".b_gnt"},     32'(b_gnt),     0);
        chk({nm, ".rf_ren"},    32'(rf_ren),    0);
        chk({nm, ".rf_wen"},    32'(rf_wen),    0);
        chk({nm, ".rf_addr"},   32'(rf_addr),   0);
        chk({nm, ".rf_wdata"},  32'(rf_wdata),  0);
        chk({nm, ".rsp_valid"}, 32'(rsp_valid), 0);
        chk({nm, ".rsp_id"},    32'(rsp_id),    0);
        chk({nm, ".rsp_err"},   32'(rsp_err),   0);
        chk({nm, ".rsp_rdata"}, 32'(rsp_rdata), 0);
        chk({nm, ".lk_status"}, 32'(lk_status), 0);
    endtask

    initial begin
        // Tie history after the A,B,A,B arbitration run is last_id = B.
        //            ar br aw bw aa    ba    ad     bd     lk rd     id ren wen ea    ew     err er
        vecs[0] = mk(1, 0, 0, 0, 4'h3, 4'h0, 8'h00, 8'h00, 0, 8'hA5, 0, 1, 0, 4'h3, 8'h00, 0, 8'hA5);
        vecs[1] = mk(0, 1, 0, 1, 4'h0, 4'h9, 8'h00, 8'h5A, 0, 8'hFF, 1, 0, 1, 4'h9, 8'h5A, 0, 8'h00);
        vecs[2] = mk(1, 1, 0, 1, 4'h5, 4'h2, 8'h00, 8'h11, 0, 8'h3C, 0, 1, 0, 4'h5, 8'h00, 0, 8'h3C);
        vecs[3] = mk(1, 1, 1, 0, 4'h7, 4'hF, 8'h77, 8'h00, 0, 8'hC3, 1, 1, 0, 4'hF, 8'h00, 0, 8'hC3);
        vecs[4] = mk(1, 0, 1, 0, 4'hC, 4'h0, 8'hEE, 8'h00, 1, 8'hFF, 0, 0, 0, 4'hC, 8'h00, 1, 8'h00);
        vecs[5] = mk(0, 1, 0, 1, 4'h0, 4'h9, 8'h00, 8'h5A, 0, 8'hFF, 1, 0, 0, 4'h9, 8'h00, 1, 8'h00);
        vecs[6] = mk(0, 1, 0, 1, 4'h0, 4'h3, 8'h00, 8'h5A, 0, 8'hFF, 1, 0, 1, 4'h3, 8'h5A, 0, 8'h00);
        vecs[7] = mk(1, 0, 0, 0, 4'hE, 4'h0, 8'h00, 8'h00, 0, 8'h99, 0, 1, 0, 4'hE, 8'h00, 0, 8'h99);
        vecs[8] = mk(1, 0, 1, 0, 4'h8, 4'h0, 8'h42, 8'h00, 0, 8'hFF, 0, 0, 0, 4'h8, 8'h00, 1, 8'h00);
        vecs[9] = mk(0, 1, 0, 1, 4'h0, 4'h7, 8'h00, 8'h24, 0, 8'hFF, 1, 0, 1, 4'h7, 8'h24, 0, 8'h00);

        reset_l = 1'b0; lk_set = 1'b0; rf_rdata = 8'h00;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

        // Requests present during reset must not produce a grant.
        #8 a_req = 1'b1; b_req = 1'b1;
        #4 chk_all_zero("reset");
        a_req = 1'b0; b_req = 1'b0;
        @(negedge rd_clk) reset_l = 1'b1;

        // Continuous tie from reset: A,B,A,B at three-cycle spacing.
        @(posedge rd_clk) #1;
        a_req = 1'b1; b_req = 1'b1; a_addr = 4'h1; b_addr = 4'h2;
        for (int i = 0; i < 12; i++) begin
            @(negedge rd_clk);
            chk($sformatf("arb[%0d].a_gnt", i), 32'(a_gnt), 32'((i % 3 == 0) && ((i / 3) % 2 == 0)));
            chk($sformatf("arb[%0d].b_gnt", i), 32'(b_gnt), 32'((i % 3 == 0) && ((i / 3) % 2 == 1)));
        end
        @(posedge rd_clk) #1;
        a_req = 1'b0; b_req = 1'b0;

        // Table: each vector is one grant / access / response triple.
        for (int i = 0; i < 10; i++) begin
            a_req = vecs[i].a_req; b_req = vecs[i].b_req;
            a_we = vecs[i].a_we;   b_we = vecs[i].b_we;
            a_addr = vecs[i].a_addr; b_addr = vecs[i].b_addr;
            a_wdata = vecs[i].a_wd;  b_wdata = vecs[i].b_wd;
            rf_rdata = 8'h00;
            @(negedge rd_clk);
            chk($sformatf("v%0d.a_gnt", i), 32'(a_gnt), 32'(vecs[i].exp_id == 1'b0));
            chk($sformatf("v%0d.b_gnt", i), 32'(b_gnt), 32'(vecs[i].exp_id == 1'b1));
            lk_set = vecs[i].lk;
            if (vecs[i].lk) lk_exp = 1'b1;
            @(posedge rd_clk) #1;
            a_req = 1'b0; b_req = 1'b0; lk_set = 1'b0;
            @(negedge rd_clk);
            chk($sformatf("v%0d.rf_ren", i),   32'(rf_ren),   32'(vecs[i].exp_ren));
            chk($sformatf("v%0d.rf_wen", i),   32'(rf_wen),   32'(vecs[i].exp_wen));
            chk($sformatf("v%0d.rf_addr", i),  32'(rf_addr),  32'(vecs[i].exp_addr));
            chk($sformatf("v%0d.rf_wdata", i), 32'(rf_wdata), 32'(vecs[i].exp_wdata));
            chk($sformatf("v%0d.acc_rsp_valid", i), 32'(rsp_valid), 0);
            @(posedge rd_clk) #1;
            rf_rdata = vecs[i].rdata;
            @(negedge rd_clk);
            chk($sformatf("v%0d.rsp_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("v%0d.rsp_id", i),    32'(rsp_id),    32'(vecs[i].exp_id));
            chk($sformatf("v%0d.rsp_err", i),   32'(rsp_err),   32'(vecs[i].exp_err));
            chk($sformatf("v%0d.rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d.rsp_rf_ren", i), 32'(rf_ren),   0);
            chk($sformatf("v%0d.lk_status", i), 32'(lk_status), 32'(lk_exp));
            @(posedge rd_clk) #1;
        end

        // Sticky lock: pulse again, then 50 cycles of toggling read requests.
        lk_set = 1'b1;
        @(posedge rd_clk) #1;
        lk_set = 1'b0;
        for (int i = 0; i < 50; i++) begin
            a_req = 1'(i % 2); a_we = 1'b0; a_addr = 4'hA;
            @(negedge rd_clk);
            chk($sformatf("sticky[%0d].lk_status", i), 32'(lk_status), 1);
            @(posedge rd_clk) #1;
        end
        a_req = 1'b0;
        repeat (3) @(posedge rd_clk);
        #1;

        // Reset with an unprotected write in ACCESS: wen must drop at once.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'h2; a_wdata = 8'h33;
        @(negedge rd_clk);
        chk("rst_wr.a_gnt", 32'(a_gnt), 1);
        @(posedge rd_clk) #1;
        a_req = 1'b0; a_we = 1'b0;
        @(negedge rd_clk);
        chk("rst_wr.rf_wen_before", 32'(rf_wen), 1);
        chk("rst_wr.lk_before",     32'(lk_status), 1);
        #2 reset_l = 1'b0;
        #1 chk_all_zero("rst_mid_access");
        @(negedge rd_clk) reset_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge rd_clk);
            chk($sformatf("post_rst[%0d].rsp_valid", i), 32'(rsp_valid), 0);
            chk($sformatf("post_rst[%0d].rf_wen", i),    32'(rf_wen),    0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
